fetch: RTL and testbench
========================

FETCH -- requirements
Module: fetch

Interface
REQ-001 Parameter RESET_PC, default 64'h8000_0000, first fetch address after reset.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 ireq_valid  output  1  instruction bus request valid.
REQ-005 ireq_addr  output  64  request address (word_t).
REQ-006 iresp_data_ok  input  1  response data valid this cycle, completes current request.
REQ-007 iresp_data  input  32  fetched instruction (u32).
REQ-008 out_valid  output  1  instruction available to decoder.
REQ-009 out_instr  output  32  raw instruction to decoder.
REQ-010 out_pc  output  64  address of out_instr.
REQ-011 out_ready  input  1  decoder accepts out_* this cycle.
REQ-012 redirect_valid  input  1  control-flow redirect (branch/jump/flush) from later stage.
REQ-013 redirect_pc  input  64  new fetch address.

Function
REQ-014 States FETCH, DISCARD, HOLD (fetch_state_t); reset state FETCH.
REQ-015 ireq_valid SHALL be 1 in FETCH when buffer occupancy plus in-flight count < depth D, and in DISCARD; 0 in HOLD.
REQ-016 Once ireq_valid rises, ireq_addr SHALL stay stable and ireq_valid high until the cycle iresp_data_ok=1.
REQ-017 FETCH: on iresp_data_ok, push {pc, iresp_data} into buffer, pc <= pc+4; next state HOLD if buffer becomes full, else FETCH.
REQ-018 HOLD -> FETCH the cycle after a pop frees a slot; no request issued in HOLD.
REQ-019 out_valid = buffer non-empty; out_instr/out_pc = buffer head; pop when out_valid && out_ready.
REQ-020 Latency: instruction visible on out_* the cycle after its iresp_data_ok; first ireq_valid the first cycle after reset_n deasserts.
REQ-021 Simultaneous push and pop on full buffer SHALL be legal only when a slot is freed same cycle; occupancy unchanged.
REQ-022 redirect_valid: buffer flushed (out_valid=0 next cycle), pc <= redirect_pc; if request in flight and no iresp_data_ok this cycle -> DISCARD, else FETCH.
REQ-023 Redirect has priority over iresp_data_ok in the same cycle; that response is dropped, not pushed.
REQ-024 DISCARD: keep old address until iresp_data_ok, drop data, -> FETCH; next request uses redirect pc.
REQ-025 Redirect while in DISCARD SHALL update pc only; remain DISCARD.
REQ-026 pc arithmetic 64-bit, wraps modulo 2^64; redirect_pc[1:0] used unmodified.

Reset
REQ-027 On reset_n=0, immediately: pc=RESET_PC, state FETCH, buffer empty, in-flight cleared, ireq_valid=0, out_valid=0, ireq_addr=RESET_PC, out_instr=0, out_pc=0.
REQ-028 Reset mid-request SHALL abandon the request; any iresp_data_ok while reset_n=0 ignored.

Configuration
REQ-029 Macro FETCH_BUF2_EN defined: buffer depth D=2, next request may issue while one entry is buffered.
REQ-030 Macro undefined: D=1, single output register; no request while out_valid=1 unless popped same cycle.
REQ-031 All other behaviour identical in both builds.

Structure
REQ-032 fetch_state_t and fetch_entry_t {pc, instr} SHALL live in package pipes; RESET_PC default constant in common.
REQ-033 Buffer SHALL be a sub-module fetch_buffer (depth-parameterised FIFO, push/pop/flush, full/empty).

Verification
REQ-034 Reset release, bus answers data_ok 1 cycle later with 32'h00000513 -> out_valid=1, out_pc=64'h8000_0000, out_instr=32'h00000513; next ireq_addr=64'h8000_0004.
REQ-035 out_ready=0 with FETCH_BUF2_EN -> exactly two responses buffered, ireq_valid=0 (HOLD); out_ready=1 -> drains in order pc 0x...00, 0x...04.
REQ-036 Redirect to 64'h8000_0100 while request outstanding -> DISCARD; returned data dropped; next ireq_addr=64'h8000_0100.
REQ-037 redirect_valid and iresp_data_ok same cycle -> no push, out_valid=0 next cycle, next ireq_addr=redirect_pc.
REQ-038 reset_n low while ireq_valid=1 -> ireq_valid and out_valid 0 asynchronously; after release ireq_addr=RESET_PC.
REQ-039 redirect_pc=64'hFFFF_FFFF_FFFF_FFFC, one fetch -> next ireq_addr=64'h0.

Source files
------------

// File: rtl/common.sv
// common: shared base types and the default reset fetch address.
package common;
  typedef logic [63:0] word_t;
  typedef logic [31:0] u32;
  localparam word_t DEFAULT_RESET_PC = 64'h8000_0000;
endpackage

// File: rtl/pipes.sv
// pipes: fetch-stage types; FETCH_BUF2_EN selects a 2-deep output buffer, otherwise 1.
package pipes;
  import common::*;
  typedef enum logic [1:0] {FETCH, DISCARD, HOLD} fetch_state_t;
  typedef struct packed {
    word_t pc;
    u32    instr;
  } fetch_entry_t;
`ifdef FETCH_BUF2_EN
  localparam int FETCH_BUF_D = 2;
`else
  localparam int FETCH_BUF_D = 1;
`endif
endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: depth-parameterised FIFO with head always at slot 0.
module fetch_buffer import pipes::*; #(
  parameter int DEPTH = 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t data_i,
  output fetch_entry_t head_o,
  output logic         full_o,
  output logic         empty_o,
  output logic [CW-1:0] count_o
);
  fetch_entry_t mem_q [DEPTH];
  fetch_entry_t nxt [DEPTH];
  logic [CW-1:0] count_q, count_d, wr_idx;
  for (genvar i = 0; i < DEPTH; i++) begin : g_shift
    if (i < DEPTH - 1) begin : g_mid
      assign nxt[i] = mem_q[i+1];
    end else begin : g_last
      assign nxt[i] = '0;
    end
  end
  always_comb begin
    count_d = flush_i ? '0 : count_q + CW'(push_i) - CW'(pop_i);
    wr_idx  = count_q - CW'(pop_i);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
    end else begin
      count_q <= count_d;
      if (!flush_i)
        for (int k = 0; k < DEPTH; k++)
          if (push_i && wr_idx == CW'(k)) mem_q[k] <= data_i;
          else if (pop_i) mem_q[k] <= nxt[k];
    end
  end
  assign head_o  = mem_q[0];
  assign full_o  = count_q == CW'(DEPTH);
  assign empty_o = count_q == '0;
  assign count_o = count_q;
endmodule

// File: rtl/fetch.sv
// fetch: instruction fetch stage with redirect/discard handling.
// Buffer depth is 2 when FETCH_BUF2_EN is defined, else 1.
module fetch import common::*, pipes::*; #(
  parameter word_t RESET_PC = DEFAULT_RESET_PC
) (
  input  logic  clk,
  input  logic  reset_n,
  output logic  ireq_valid,
  output word_t ireq_addr,
  input  logic  iresp_data_ok,
  input  u32    iresp_data,
  output logic  out_valid,
  output u32    out_instr,
  output word_t out_pc,
  input  logic  out_ready,
  input  logic  redirect_valid,
  input  word_t redirect_pc
);
  localparam int CW = $clog2(FETCH_BUF_D + 1);
  fetch_state_t state_q, state_d;
  word_t pc_q, pc_d, addr_q, addr_d;
  logic req_q, req_d, keep, push, pop, full, empty;
  logic [CW-1:0] cnt, occ_d;
  fetch_entry_t head;
  always_comb begin
    keep    = req_q && !iresp_data_ok;
    pop     = !empty && out_ready && !redirect_valid;
    push    = state_q == FETCH && req_q && iresp_data_ok && !redirect_valid && (!full || pop);
    pc_d    = redirect_valid ? redirect_pc : push ? pc_q + 64'd4 : pc_q;
    occ_d   = redirect_valid ? '0 : cnt + CW'(push) - CW'(pop);
    // An outstanding request is never abandoned: its response is awaited in DISCARD.
    state_d = (redirect_valid || state_q == DISCARD) ? (keep ? DISCARD : FETCH)
            : (occ_d == CW'(FETCH_BUF_D) ? HOLD : FETCH);
    req_d   = state_d != HOLD;
    addr_d  = keep ? addr_q : pc_d;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
    end
  end
  fetch_buffer #(.DEPTH(FETCH_BUF_D)) u_buf (
    .clk     (clk),
    .rst_n   (reset_n),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect_valid),
    .data_i  ('{pc: pc_q, instr: iresp_data}),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (cnt)
  );
  assign ireq_valid = req_q;
  assign ireq_addr  = addr_q;
  assign out_valid  = !empty;
  assign out_instr  = head.instr;
  assign out_pc     = head.pc;
endmodule

// File: tb/tb_fetch.sv
// tb_fetch: randomized + directed check of fetch against a transaction-level model.
module tb_fetch;
  localparam logic [63:0] RST_PC = 64'h8000_0000;
`ifdef FETCH_BUF2_EN
  localparam int D = 2;
`else
  localparam int D = 1;
`endif
  logic clk = 1'b0, reset_n = 1'b0, iresp_data_ok = 1'b0, out_ready = 1'b0, redirect_valid = 1'b0;
  logic [31:0] iresp_data = '0;
  logic [63:0] redirect_pc = '0;
  logic ireq_valid, out_valid;
  logic [63:0] ireq_addr, out_pc;
  logic [31:0] out_instr;
  int vecs = 0, errs = 0;
  typedef struct {
    logic [63:0] pc;
    logic [31:0] ins;
  } ent_t;
  ent_t q[$];
  bit m_busy, m_drop;
  logic [63:0] m_addr, m_pc;
  fetch dut (
    .clk(clk), .reset_n(reset_n), .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data), .out_valid(out_valid),
    .out_instr(out_instr), .out_pc(out_pc), .out_ready(out_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    vecs++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s got=%h exp=%h t=%0t", n, a, e, $time);
    end
  endtask
  task automatic compare();
    chk("ireq_valid", ireq_valid, m_busy);
    chk("ireq_addr", ireq_addr, m_addr);
    chk("out_valid", out_valid, q.size() > 0);
    if (q.size() > 0) begin
      chk("out_pc", out_pc, q[0].pc);
      chk("out_instr", out_instr, q[0].ins);
    end
  endtask
  task automatic model_reset();
    m_busy = 0; m_drop = 0; m_addr = RST_PC; m_pc = RST_PC;
    q.delete();
  endtask
  // Transaction view: one outstanding request, a queue of up to D fetched words.
  task automatic model_step();
    if (redirect_valid) begin
      q.delete();
      if (m_busy && !iresp_data_ok) m_drop = 1;
      else begin m_busy = 0; m_drop = 0; end
      m_pc = redirect_pc;
    end else begin
      if (out_ready && q.size() > 0) void'(q.pop_front());
      if (m_busy && iresp_data_ok) begin
        if (!m_drop) begin
          q.push_back('{m_addr, iresp_data});
          m_pc = m_addr + 64'd4;
        end
        m_busy = 0; m_drop = 0;
      end
    end
    if (!m_busy) begin
      m_addr = m_pc;
      m_busy = q.size() < D;
    end
  endtask
  task automatic cycle(input bit ok, input logic [31:0] d, input bit rdy, input bit rv, input logic [63:0] rpc);
    iresp_data_ok = ok && m_busy;
    iresp_data = d; out_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
    model_step();
    @(negedge clk);
    compare();
  endtask
  task automatic do_reset();
    #2 reset_n = 1'b0;
    iresp_data_ok = 1'b1; redirect_valid = 1'b0;
    #1;
    chk("rst_ireq_valid", ireq_valid, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_ireq_addr", ireq_addr, RST_PC);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_instr", out_instr, 0);
    model_reset();
    repeat (2) @(negedge clk);
    iresp_data_ok = 1'b0; reset_n = 1'b1;
    compare();
  endtask
  initial begin
    @(negedge clk);
    do_reset();
    cycle(0, 0, 0, 0, 0);
    chk("first_req_valid", ireq_valid, 1);
    chk("first_req_addr", ireq_addr, RST_PC);
    cycle(1, 32'h0000_0513, 0, 0, 0);
    chk("first_out_valid", out_valid, 1);
    chk("first_out_pc", out_pc, RST_PC);
    chk("first_out_instr", out_instr, 32'h0000_0513);
    chk("next_req_addr", ireq_addr, 64'h8000_0004);
    cycle(1, 32'h0010_0093, 0, 0, 0);
    chk("hold_no_req", ireq_valid, 0);
    chk("hold_head_pc", out_pc, RST_PC);
    cycle(0, 0, 1, 0, 0);
    chk("hold_release_req", ireq_valid, 1);
    repeat (4) cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 0, 1, 64'h8000_0100);
    chk("discard_keeps_req", ireq_valid, 1);
    chk("redirect_flush", out_valid, 0);
    cycle(1, 32'hdead_beef, 0, 0, 0);
    chk("discard_drop", out_valid, 0);
    chk("discard_new_addr", ireq_addr, 64'h8000_0100);
    chk("discard_new_valid", ireq_valid, 1);
    cycle(1, 32'h0000_0013, 0, 1, 64'h8000_0200);
    chk("redir_ok_nopush", out_valid, 0);
    chk("redir_ok_addr", ireq_addr, 64'h8000_0200);
    cycle(0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC);
    cycle(1, 32'h1, 0, 0, 0);
    chk("wrap_req_addr", ireq_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    cycle(1, 32'h2, 0, 0, 0);
    chk("wrap_next_addr", ireq_addr, 64'h0);
    chk("wrap_out_pc", out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_out_instr", out_instr, 32'h2);
    cycle(0, 0, 1, 0, 0);
    chk("midreq_valid", ireq_valid, 1);
    do_reset();
    cycle(0, 0, 0, 0, 0);
    chk("rel_addr", ireq_addr, RST_PC);
    chk("rel_valid", ireq_valid, 1);
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      else cycle($urandom_range(0, 2) != 0, $urandom(), $urandom_range(0, 9) < 7,
                 $urandom_range(0, 14) == 0, {$urandom(), $urandom()});
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
